// File: rtl/simon_serial_ctrl.sv
// Control sequencer for the bit-serial Simon 128/128 core: idle, serial load, 68 rounds, serial drain.
// Optional abort input is enabled by defining SIMON_CTRL_ABORT_EN.
module simon_serial_ctrl #(
    parameter int unsigned ROUNDS    = 68,
    parameter int unsigned LOAD_BITS = 256,
    parameter int unsigned OUT_BITS  = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef SIMON_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic [1:0] data_rdy,
    output logic [5:0] bit_counter,
    output logic [6:0] round_idx,
    output logic       out_shift,
    output logic       busy,
    output logic       done
);

    localparam int unsigned LOAD_W  = $clog2(LOAD_BITS);
    localparam int unsigned OUT_W   = $clog2(OUT_BITS);
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned ROUND_W = 7;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_HOLD = 2'd1;
    localparam logic [1:0] PH_LOAD = 2'd2;
    localparam logic [1:0] PH_RUN  = 2'd3;

    localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(LOAD_BITS - 1);
    localparam logic [OUT_W-1:0]   OUT_LAST   = OUT_W'(OUT_BITS - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(63);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    state_t             state;
    logic [LOAD_W-1:0]  load_cnt;
    logic [OUT_W-1:0]   out_cnt;
    logic [BIT_W-1:0]   run_bit;
    logic               abort_hit;

`ifdef SIMON_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Handshake strobes depend on state only, so no in_valid/out_ready -> ready/valid path exists.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_shift   = 1'b0;
        data_rdy    = PH_IDLE;
        bit_counter = '0;
        case (state)
            IDLE: begin
                data_rdy = PH_IDLE;
            end
            LOAD: begin
                in_ready    = 1'b1;
                data_rdy    = in_valid ? PH_LOAD : PH_HOLD;
                bit_counter = BIT_W'(load_cnt);
            end
            RUN: begin
                data_rdy    = PH_RUN;
                bit_counter = run_bit;
            end
            DRAIN: begin
                out_valid   = 1'b1;
                out_shift   = out_ready;
                data_rdy    = PH_HOLD;
                bit_counter = BIT_W'(out_cnt);
            end
            default: begin
                data_rdy = PH_IDLE;
            end
        endcase
    end

    // Sequencer state and counters; every path back to IDLE leaves all counters cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            out_cnt   <= '0;
            run_bit   <= '0;
            round_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort_hit) begin
            state     <= IDLE;
            load_cnt  <= '0;
            out_cnt   <= '0;
            run_bit   <= '0;
            round_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        load_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (load_cnt == LOAD_LAST) begin
                            state     <= RUN;
                            load_cnt  <= '0;
                            run_bit   <= '0;
                            round_idx <= '0;
                        end else begin
                            load_cnt <= load_cnt + LOAD_W'(1);
                        end
                    end
                end
                RUN: begin
                    run_bit <= run_bit + BIT_W'(1);
                    if (run_bit == BIT_LAST) begin
                        if (round_idx == ROUND_LAST) begin
                            state   <= DRAIN;
                            out_cnt <= '0;
                        end else begin
                            round_idx <= round_idx + ROUND_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_cnt == OUT_LAST) begin
                            state     <= IDLE;
                            out_cnt   <= '0;
                            run_bit   <= '0;
                            round_idx <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_cnt <= out_cnt + OUT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_serial_ctrl.sv
// Scoreboard bench for simon_serial_ctrl: a phase/bit-count model predicts every cycle's outputs.
module tb_simon_serial_ctrl;

    localparam int ROUNDS    = 68;
    localparam int LOAD_BITS = 256;
    localparam int OUT_BITS  = 128;
    localparam int RUN_CYC   = ROUNDS * 64;
    localparam int FULL_LAT  = LOAD_BITS + RUN_CYC + OUT_BITS + 1;
    localparam int BUDGET    = 20000;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, out_ready, abort;
    logic       in_ready, out_valid, out_shift, busy, done;
    logic [1:0] data_rdy;
    logic [5:0] bit_counter;
    logic [6:0] round_idx;

    always #5 clk = ~clk;

    simon_serial_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SIMON_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .data_rdy   (data_rdy),
        .bit_counter(bit_counter),
        .round_idx  (round_idx),
        .out_shift  (out_shift),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       out_shift;
        logic       busy;
        logic       done;
        logic [1:0] data_rdy;
        logic [5:0] bit_counter;
        logic [6:0] round_idx;
    } obs_t;

    obs_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    bit   lat_armed = 1'b0;

    // Reference model: phase 0 idle, 1 load, 2 run, 3 drain, plus plain progress counts.
    int m_phase, m_loaded, m_runcyc, m_out;
    bit m_done;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t model_out(input logic iv, input logic ordy);
        obs_t o;
        o = '0;
        o.in_ready  = (m_phase == 1);
        o.out_valid = (m_phase == 3);
        o.out_shift = (m_phase == 3) && ordy;
        o.busy      = (m_phase != 0);
        o.done      = m_done;
        case (m_phase)
            1: begin
                o.data_rdy    = iv ? 2'd2 : 2'd1;
                o.bit_counter = 6'(m_loaded % 64);
            end
            2: begin
                o.data_rdy    = 2'd3;
                o.bit_counter = 6'(m_runcyc % 64);
                o.round_idx   = 7'(m_runcyc / 64);
            end
            3: begin
                o.data_rdy    = 2'd1;
                o.bit_counter = 6'(m_out % 64);
                o.round_idx   = 7'(ROUNDS - 1);
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_loaded = 0; m_runcyc = 0; m_out = 0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic rs, input logic st, input logic iv,
                              input logic ordy, input logic ab);
        if (!rs) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
`ifdef SIMON_CTRL_ABORT_EN
        if (ab && m_phase != 0) begin
            model_reset();
            return;
        end
`endif
        case (m_phase)
            0: if (st) begin m_phase = 1; m_loaded = 0; end
            1: if (iv) begin
                m_loaded++;
                if (m_loaded == LOAD_BITS) begin m_phase = 2; m_runcyc = 0; end
            end
            2: begin
                m_runcyc++;
                if (m_runcyc == RUN_CYC) begin m_phase = 3; m_out = 0; end
            end
            3: if (ordy) begin
                m_out++;
                if (m_out == OUT_BITS) begin m_phase = 0; m_done = 1'b1; end
            end
            default: model_reset();
        endcase
    endtask

    // One clock of stimulus: drive, queue the prediction, then advance the model at the edge.
    task automatic cycle(input logic rs, input logic st, input logic iv,
                         input logic ordy, input logic ab);
        reset = rs; start = st; in_valid = iv; out_ready = ordy; abort = ab;
        exp_q.push_back(model_out(iv, ordy));
        @(posedge clk);
        model_step(rs, st, iv, ordy, ab);
        #1;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.in_ready = in_ready; a.out_valid = out_valid; a.out_shift = out_shift;
            a.busy = busy; a.done = done; a.data_rdy = data_rdy;
            a.bit_counter = bit_counter; a.round_idx = round_idx;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs cyc=%0d got rdy=%0d bc=%0d rnd=%0d ir=%b ov=%b sh=%b busy=%b done=%b want rdy=%0d bc=%0d rnd=%0d ir=%b ov=%b sh=%b busy=%b done=%b",
                         cyc, a.data_rdy, a.bit_counter, a.round_idx, a.in_ready, a.out_valid,
                         a.out_shift, a.busy, a.done, e.data_rdy, e.bit_counter, e.round_idx,
                         e.in_ready, e.out_valid, e.out_shift, e.busy, e.done);
            end
            if (lat_armed && done === 1'b1) begin
                lat_armed = 1'b0;
                checks++;
                if (cyc - start_cyc != FULL_LAT) begin
                    failures++;
                    $display("FAIL done_latency got %0d want %0d", cyc - start_cyc, FULL_LAT);
                end
            end
        end
    end

    // iv_mode: 0 always valid, 1 drop every 3rd load cycle, 2 random.
    // or_mode: 0 always ready, 1 random, 2 hold off 20 cycles at bit 64.
    task automatic run_txn(input int iv_mode, input int or_mode, input bit spurious,
                           input int rst_at, input int abort_load, input int abort_drain,
                           input bit chk_lat);
        int   n, k, stall;
        logic iv, ordy, st, rs, ab;
        n = 0; k = 0; stall = 0;
        start_cyc = cyc;
        lat_armed = chk_lat;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        while (m_phase != 0 && n < BUDGET) begin
            iv = 1'b1;
            if (iv_mode == 1) iv = (k % 3) != 2;
            else if (iv_mode == 2) iv = $urandom_range(0, 3) != 0;
            if (m_phase == 1) k++;
            ordy = 1'b1;
            if (or_mode == 1) ordy = $urandom_range(0, 2) != 0;
            else if (or_mode == 2 && m_phase == 3 && m_out == 64 && stall < 20) begin
                ordy = 1'b0;
                stall++;
            end
            st = spurious && (m_phase == 2) && ($urandom_range(0, 15) == 0);
            rs = !(rst_at >= 0 && m_phase == 2 && m_runcyc == rst_at);
            ab = (abort_load >= 0 && m_phase == 1 && m_loaded == abort_load) ||
                 (abort_drain >= 0 && m_phase == 3 && m_out == abort_drain);
            cycle(rs, st, iv, ordy, ab);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout got %0d cycles want < %0d", n, BUDGET);
        end
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        if (chk_lat) begin
            checks++;
            if (lat_armed) begin
                failures++;
                $display("FAIL done_seen got 0 want 1");
            end
        end
        lat_armed = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        // start is driven during reset and must lose
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        run_txn(0, 0, 1'b0, -1, -1, -1, 1'b1);
        run_txn(1, 0, 1'b1, -1, -1, -1, 1'b0);
        run_txn(0, 2, 1'b0, -1, -1, -1, 1'b0);
        run_txn(0, 0, 1'b0, 30 * 64 + 17, -1, -1, 1'b0);
        run_txn(0, 0, 1'b0, -1, -1, -1, 1'b1);
        run_txn(2, 1, 1'b1, -1, -1, -1, 1'b0);
`ifdef SIMON_CTRL_ABORT_EN
        run_txn(0, 0, 1'b0, -1, 100, -1, 1'b0);
        run_txn(2, 0, 1'b1, -1, -1, 50, 1'b0);
        run_txn(0, 0, 1'b0, -1, -1, -1, 1'b1);
`endif
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
